// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel-side column/row protocol receiver
//
// Oversamples the LED-matrix shift clock, latch strobe, output enable,
// row select and per-lane RGB data in the clk_i domain. Column bits are
// shifted into per-lane registers and copied to the parallel row outputs
// on each latch strobe.
//
// Optional feature: define HUB75_RX_ONTIME_EN to build the display on-time
// counter; without it on_time_o is tied to 0.
//
// Ports:
//   clk_i, rst_i                    system clock, async active-high reset
//   led_clk_i / led_stb_i           column shift clock / latch strobe (rising edges)
//   led_oe_i                        output enable, active low
//   led_row_i[4:0]                  row/module select
//   led_r_i/led_g_i/led_b_i         serial colour data, one bit per lane
//   row_r_o/row_g_o/row_b_o         latched row data, lane L at [L*COLS +: COLS]
//   row_addr_o                      row select captured at latch
//   row_valid_o / frame_start_o     one-cycle pulses on latch (frame: address 0)
//   disp_en_o                       synchronized inverse of led_oe_i
//   len_err_o                       sticky: latch with shift count != COLS
//   shift_cnt_o                     shift edges since last latch, saturating
//   on_time_o                       display-enabled cycles in previous row period

module hub75_rx #(
    parameter int COLS        = 16,
    parameter int LANES       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     led_clk_i,
    input  logic                     led_stb_i,
    input  logic                     led_oe_i,
    input  logic [4:0]               led_row_i,
    input  logic [LANES-1:0]         led_r_i,
    input  logic [LANES-1:0]         led_g_i,
    input  logic [LANES-1:0]         led_b_i,
    output logic [LANES*COLS-1:0]    row_r_o,
    output logic [LANES*COLS-1:0]    row_g_o,
    output logic [LANES*COLS-1:0]    row_b_o,
    output logic [4:0]               row_addr_o,
    output logic                     row_valid_o,
    output logic                     frame_start_o,
    output logic                     disp_en_o,
    output logic                     len_err_o,
    output logic [7:0]               shift_cnt_o,
    output logic [15:0]              on_time_o
);

    // All protocol inputs travel through one bus so data, row and control
    // share exactly the same synchronizer depth and stay aligned.
    // Bus layout, MSB first: {clk, stb, oe, row[4:0], r, g, b}.
    localparam int SW = 8 + 3 * LANES;
    // Reset value keeps oe inactive (high) so no false edge or enable appears.
    localparam logic [SW-1:0] SYNC_RST = {3'b001, {(SW-3){1'b0}}};
    localparam logic [7:0]    COLS8    = 8'(COLS);

    logic [SW-1:0] r_sync [SYNC_STAGES];
    logic [SW-1:0] w_in;
    logic [SW-1:0] w_s;

    assign w_in = {led_clk_i, led_stb_i, led_oe_i, led_row_i, led_r_i, led_g_i, led_b_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= SYNC_RST;
            end
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    logic             w_s_clk;
    logic             w_s_stb;
    logic             w_s_oe;
    logic [4:0]       w_s_row;
    logic [LANES-1:0] w_s_r;
    logic [LANES-1:0] w_s_g;
    logic [LANES-1:0] w_s_b;

    assign w_s_clk = w_s[SW-1];
    assign w_s_stb = w_s[SW-2];
    assign w_s_oe  = w_s[SW-3];
    assign w_s_row = w_s[3*LANES +: 5];
    assign w_s_r   = w_s[2*LANES +: LANES];
    assign w_s_g   = w_s[LANES +: LANES];
    assign w_s_b   = w_s[0 +: LANES];

    // Edge detection on the synchronized control signals.
    logic r_clk_d;
    logic r_stb_d;
    logic w_shift;
    logic w_latch;

    assign w_shift = w_s_clk & ~r_clk_d;
    assign w_latch = w_s_stb & ~r_stb_d;

    logic [LANES*COLS-1:0] r_sr_r;
    logic [LANES*COLS-1:0] r_sr_g;
    logic [LANES*COLS-1:0] r_sr_b;
    logic [LANES*COLS-1:0] w_sr_r_upd;
    logic [LANES*COLS-1:0] w_sr_g_upd;
    logic [LANES*COLS-1:0] w_sr_b_upd;
    logic [7:0]            w_cnt_upd;

    // Post-shift view of the registers and counter; a latch in the same
    // cycle as a shift edge therefore captures the new bit and count.
    always_comb begin
        w_sr_r_upd = r_sr_r;
        w_sr_g_upd = r_sr_g;
        w_sr_b_upd = r_sr_b;
        w_cnt_upd  = shift_cnt_o;
        if (w_shift) begin
            for (int l = 0; l < LANES; l++) begin
                w_sr_r_upd[l*COLS +: COLS] = {r_sr_r[l*COLS +: COLS-1], w_s_r[l]};
                w_sr_g_upd[l*COLS +: COLS] = {r_sr_g[l*COLS +: COLS-1], w_s_g[l]};
                w_sr_b_upd[l*COLS +: COLS] = {r_sr_b[l*COLS +: COLS-1], w_s_b[l]};
            end
            if (shift_cnt_o != 8'hFF) begin
                w_cnt_upd = shift_cnt_o + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_d       <= 1'b0;
            r_stb_d       <= 1'b0;
            r_sr_r        <= '0;
            r_sr_g        <= '0;
            r_sr_b        <= '0;
            row_r_o       <= '0;
            row_g_o       <= '0;
            row_b_o       <= '0;
            row_addr_o    <= '0;
            row_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            disp_en_o     <= 1'b0;
            len_err_o     <= 1'b0;
            shift_cnt_o   <= '0;
        end else begin
            r_clk_d       <= w_s_clk;
            r_stb_d       <= w_s_stb;
            disp_en_o     <= ~w_s_oe;
            row_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            r_sr_r        <= w_sr_r_upd;
            r_sr_g        <= w_sr_g_upd;
            r_sr_b        <= w_sr_b_upd;
            shift_cnt_o   <= w_cnt_upd;
            if (w_latch) begin
                row_r_o       <= w_sr_r_upd;
                row_g_o       <= w_sr_g_upd;
                row_b_o       <= w_sr_b_upd;
                row_addr_o    <= w_s_row;
                row_valid_o   <= 1'b1;
                frame_start_o <= (w_s_row == 5'd0);
                shift_cnt_o   <= '0;
                if (w_cnt_upd != COLS8) begin
                    len_err_o <= 1'b1;
                end
            end
        end
    end

`ifdef HUB75_RX_ONTIME_EN
    logic [15:0] r_on_cnt;
    logic [15:0] w_on_upd;

    // Include this cycle's enable so the copied value covers the full period.
    assign w_on_upd = (disp_en_o && r_on_cnt != 16'hFFFF) ? r_on_cnt + 16'd1 : r_on_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_on_cnt  <= '0;
            on_time_o <= '0;
        end else if (w_latch) begin
            on_time_o <= w_on_upd;
            r_on_cnt  <= '0;
        end else begin
            r_on_cnt  <= w_on_upd;
        end
    end
`else
    assign on_time_o = '0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - randomized self-checking bench for hub75_rx

module tb_hub75_rx;

    localparam int COLS  = 16;
    localparam int LANES = 4;
    localparam int SS    = 2;
    localparam int W     = LANES * COLS;
`ifdef HUB75_RX_ONTIME_EN
    localparam bit ONT = 1'b1;
`else
    localparam bit ONT = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             led_clk_i = 1'b0;
    logic             led_stb_i = 1'b0;
    logic             led_oe_i = 1'b1;
    logic [4:0]       led_row_i = '0;
    logic [LANES-1:0] led_r_i = '0;
    logic [LANES-1:0] led_g_i = '0;
    logic [LANES-1:0] led_b_i = '0;
    logic [W-1:0]     row_r_o;
    logic [W-1:0]     row_g_o;
    logic [W-1:0]     row_b_o;
    logic [4:0]       row_addr_o;
    logic             row_valid_o;
    logic             frame_start_o;
    logic             disp_en_o;
    logic             len_err_o;
    logic [7:0]       shift_cnt_o;
    logic [15:0]      on_time_o;

    hub75_rx #(.COLS(COLS), .LANES(LANES), .SYNC_STAGES(SS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .led_clk_i(led_clk_i), .led_stb_i(led_stb_i), .led_oe_i(led_oe_i),
        .led_row_i(led_row_i), .led_r_i(led_r_i), .led_g_i(led_g_i), .led_b_i(led_b_i),
        .row_r_o(row_r_o), .row_g_o(row_g_o), .row_b_o(row_b_o),
        .row_addr_o(row_addr_o), .row_valid_o(row_valid_o), .frame_start_o(frame_start_o),
        .disp_en_o(disp_en_o), .len_err_o(len_err_o), .shift_cnt_o(shift_cnt_o),
        .on_time_o(on_time_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: history of every bit shifted per colour/lane since
    // reset; a latched lane is the last COLS bits, oldest at the MSB.
    bit q_hist [3][LANES][$];
    int m_cnt;
    bit m_err;
    int m_ot;

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int l = 0; l < LANES; l++) q_hist[c][l].delete();
        m_cnt = 0;
        m_err = 1'b0;
        m_ot  = 0;
    endtask

    task automatic model_push(input logic [LANES-1:0] r, input logic [LANES-1:0] g,
                              input logic [LANES-1:0] b);
        for (int l = 0; l < LANES; l++) begin
            q_hist[0][l].push_back(r[l]);
            q_hist[1][l].push_back(g[l]);
            q_hist[2][l].push_back(b[l]);
            for (int c = 0; c < 3; c++)
                if (q_hist[c][l].size() > COLS) void'(q_hist[c][l].pop_front());
        end
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    endtask

    function automatic logic [W-1:0] model_row(input int c);
        logic [W-1:0] v = '0;
        for (int l = 0; l < LANES; l++) begin
            int n = q_hist[c][l].size();
            for (int i = 0; i < COLS; i++)
                if (n - 1 - i >= 0) v[l*COLS + i] = q_hist[c][l][n-1-i];
        end
        return v;
    endfunction

    task automatic shift_one(input logic [LANES-1:0] r, input logic [LANES-1:0] g,
                             input logic [LANES-1:0] b);
        led_r_i = r; led_g_i = g; led_b_i = b;
        repeat (2) @(negedge clk_i);
        led_clk_i = 1'b1;
        model_push(r, g, b);
        repeat (2) @(negedge clk_i);
        led_clk_i = 1'b0;
    endtask

    // Shifts n columns; column i of each lane word is bit COLS-1-i so the
    // word reads MSB-first once latched. Columns beyond COLS are random.
    task automatic shift_words(input logic [W-1:0] wr, input logic [W-1:0] wg,
                               input logic [W-1:0] wb, input int n);
        logic [LANES-1:0] r, g, b;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < LANES; l++) begin
                if (i < COLS) begin
                    r[l] = wr[l*COLS + COLS-1-i];
                    g[l] = wg[l*COLS + COLS-1-i];
                    b[l] = wb[l*COLS + COLS-1-i];
                end else begin
                    r[l] = 1'($urandom); g[l] = 1'($urandom); b[l] = 1'($urandom);
                end
            end
            shift_one(r, g, b);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic latch_row(input logic [4:0] addr, input bit with_shift,
                             input logic [LANES-1:0] r, input logic [LANES-1:0] g,
                             input logic [LANES-1:0] b);
        logic [W-1:0] er, eg, eb;
        logic [15:0]  eot;
        int cyc;
        led_row_i = addr;
        if (with_shift) begin
            led_r_i = r; led_g_i = g; led_b_i = b;
        end
        repeat (2) @(negedge clk_i);
        if (with_shift) begin
            led_clk_i = 1'b1;
            model_push(r, g, b);
        end
        led_stb_i = 1'b1;
        er = model_row(0); eg = model_row(1); eb = model_row(2);
        if (m_cnt != COLS) m_err = 1'b1;
        m_cnt = 0;
        eot = ONT ? 16'(m_ot) : 16'd0;
        m_ot = 0;
        cyc = 0;
        do begin
            @(posedge clk_i); #1;
            cyc++;
        end while (!row_valid_o && cyc < 20);
        check_eq("valid_latency", 64'(cyc), 64'(SS + 1));
        check_eq("row_r", row_r_o, er);
        check_eq("row_g", row_g_o, eg);
        check_eq("row_b", row_b_o, eb);
        check_eq("row_addr", 64'(row_addr_o), 64'(addr));
        check_eq("frame_start", 64'(frame_start_o), 64'(addr == 5'd0));
        check_eq("len_err", 64'(len_err_o), 64'(m_err));
        check_eq("shift_cnt_clr", 64'(shift_cnt_o), 64'd0);
        check_eq("on_time", 64'(on_time_o), 64'(eot));
        @(posedge clk_i); #1;
        check_eq("valid_pulse_end", 64'(row_valid_o), 64'd0);
        @(negedge clk_i);
        led_clk_i = 1'b0;
        led_stb_i = 1'b0;
        repeat (SS + 2) @(negedge clk_i);
    endtask

    task automatic check_count();
        repeat (SS) @(negedge clk_i);
        check_eq("shift_cnt", 64'(shift_cnt_o), 64'(m_cnt));
    endtask

    task automatic do_reset();
        int nv;
        @(negedge clk_i);
        rst_i = 1'b1;
        led_clk_i = 1'b0; led_stb_i = 1'b0; led_oe_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_row_r", row_r_o, '0);
        check_eq("rst_row_addr", 64'(row_addr_o), 64'd0);
        check_eq("rst_flags", 64'({row_valid_o, frame_start_o, len_err_o, disp_en_o}), 64'd0);
        check_eq("rst_shift_cnt", 64'(shift_cnt_o), 64'd0);
        check_eq("rst_on_time", 64'(on_time_o), 64'd0);
        model_reset();
        rst_i = 1'b0;
        nv = 0;
        repeat (SS + 3) begin
            @(posedge clk_i); #1;
            if (row_valid_o) nv++;
        end
        check_eq("rst_no_valid", 64'(nv), 64'd0);
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int n;
        logic [4:0] a;
        model_reset();
        repeat (3) @(negedge clk_i);
        do_reset();

        // Single marker bit on lane 0 red.
        shift_words(64'h0000_0000_0000_8000, '0, '0, COLS);
        check_count();
        latch_row(5'd3, 1'b0, '0, '0, '0);
        check_eq("r_lane0", 64'(row_r_o[15:0]), 64'h8000);

        // Distinct green patterns per lane, row 19.
        shift_words(rnd_word(), {16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5}, rnd_word(), COLS);
        latch_row(5'd19, 1'b0, '0, '0, '0);
        check_eq("g_lanes", row_g_o, {16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5});

        // Row 0 gives frame start; short row sets sticky error.
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS);
        latch_row(5'd0, 1'b0, '0, '0, '0);
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS - 1);
        check_count();
        latch_row(5'd4, 1'b0, '0, '0, '0);
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS);
        latch_row(5'd5, 1'b0, '0, '0, '0);
        latch_row(5'd6, 1'b0, '0, '0, '0);

        // Shift edge and strobe in the same cycle as the 16th column.
        do_reset();
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS - 1);
        latch_row(5'd9, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom));

        // Display enable window of 100 cycles between latches.
        @(negedge clk_i);
        led_oe_i = 1'b0;
        first = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i); #1;
            if (disp_en_o && first < 0) first = i + 1;
        end
        check_eq("disp_en_latency", 64'(first), 64'(SS + 1));
        @(negedge clk_i);
        led_oe_i = 1'b1;
        m_ot += 100;
        repeat (SS + 3) @(negedge clk_i);
        check_eq("disp_en_off", 64'(disp_en_o), 64'd0);
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS);
        latch_row(5'd10, 1'b0, '0, '0, '0);

        // Reset mid-row discards partial shifts.
        shift_words(rnd_word(), rnd_word(), rnd_word(), 7);
        do_reset();
        shift_words(rnd_word(), rnd_word(), rnd_word(), COLS);
        latch_row(5'd11, 1'b0, '0, '0, '0);

        // Randomized rows, occasionally with wrong length.
        for (int k = 0; k < 8; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : COLS;
            a = 5'($urandom);
            shift_words(rnd_word(), rnd_word(), rnd_word(), n);
            check_count();
            latch_row(a, 1'b0, '0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
